// File: rtl/seq_pattern_tx_if.sv
// Handshake and serial-output bundle for seq_pattern_tx.
// The master drives the request side and the slave (the transmitter) drives the serial side.
interface seq_pattern_tx_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
);
    // valid/ready: a request transfers on a rising edge where in_valid && in_ready.
    // in_valid may rise at any time and is ignored while in_ready is low.
    // in_data/in_reps only need to be stable at that accepting edge.
    logic [WIDTH-1:0] in_data;
    logic [CNT_W-1:0] in_reps;
    logic             in_valid;
    logic             in_ready;
    logic             out;
    logic             out_valid;
    logic             out_last;
    logic             done;
    logic             busy;

    modport master (
        output in_data, in_reps, in_valid,
        input  in_ready, out, out_valid, out_last, done, busy
    );

    modport slave (
        input  in_data, in_reps, in_valid,
        output in_ready, out, out_valid, out_last, done, busy
    );
endinterface

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts a captured word out MSB-first, repeated back-to-back.
// Define SEQ_PATTERN_TX_PARITY_EN to append an even-parity bit after every repetition.
module seq_pattern_tx #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    seq_pattern_tx_if.slave    bus,
    output logic [1:0]         dbg_state
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
    localparam logic [BW-1:0] PENULT_BIT = BW'(WIDTH - 2);

`ifdef SEQ_PATTERN_TX_PARITY_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2,
        DONE  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd3
    } state_t;
`endif

    state_t           state;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] shreg;
    logic [CNT_W-1:0] reps;
    logic [BW-1:0]    bitcnt;

    logic             ser;
    logic             ser_valid;
    logic             ser_last;
    logic             done_q;
    logic             ready_q;
    logic             busy_q;

    logic             accept;
    logic             word_end;
    logic             last_rep;
    logic [CNT_W-1:0] reps_load;

    assign accept    = bus.in_valid && ready_q;
    assign word_end  = (bitcnt == LAST_BIT);
    assign last_rep  = (reps <= CNT_W'(1));
    assign reps_load = (bus.in_reps == '0) ? CNT_W'(1) : bus.in_reps;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            word      <= '0;
            shreg     <= '0;
            reps      <= '0;
            bitcnt    <= '0;
            ser       <= 1'b0;
            ser_valid <= 1'b0;
            ser_last  <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        // The MSB goes straight to the output register; shreg holds what follows.
                        word      <= bus.in_data;
                        shreg     <= {bus.in_data[WIDTH-2:0], 1'b0};
                        reps      <= reps_load;
                        bitcnt    <= '0;
                        ser       <= bus.in_data[WIDTH-1];
                        ser_valid <= 1'b1;
                        ser_last  <= 1'b0;
                        ready_q   <= 1'b0;
                        busy_q    <= 1'b1;
                        state     <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (!word_end) begin
                        ser    <= shreg[WIDTH-1];
                        shreg  <= {shreg[WIDTH-2:0], 1'b0};
                        bitcnt <= bitcnt + BW'(1);
`ifdef SEQ_PATTERN_TX_PARITY_EN
                        ser_last <= 1'b0;
`else
                        ser_last <= last_rep && (bitcnt == PENULT_BIT);
`endif
                    end else begin
`ifdef SEQ_PATTERN_TX_PARITY_EN
                        ser      <= ^word;
                        ser_last <= last_rep;
                        state    <= PAR;
`else
                        if (!last_rep) begin
                            reps     <= reps - CNT_W'(1);
                            shreg    <= {word[WIDTH-2:0], 1'b0};
                            bitcnt   <= '0;
                            ser      <= word[WIDTH-1];
                            ser_last <= 1'b0;
                        end else begin
                            ser       <= 1'b0;
                            ser_valid <= 1'b0;
                            ser_last  <= 1'b0;
                            done_q    <= 1'b1;
                            state     <= DONE;
                        end
`endif
                    end
                end

`ifdef SEQ_PATTERN_TX_PARITY_EN
                PAR: begin
                    if (!last_rep) begin
                        reps     <= reps - CNT_W'(1);
                        shreg    <= {word[WIDTH-2:0], 1'b0};
                        bitcnt   <= '0;
                        ser      <= word[WIDTH-1];
                        ser_last <= 1'b0;
                        state    <= SHIFT;
                    end else begin
                        ser       <= 1'b0;
                        ser_valid <= 1'b0;
                        ser_last  <= 1'b0;
                        done_q    <= 1'b1;
                        state     <= DONE;
                    end
                end
`endif

                DONE: begin
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state   <= IDLE;
                end

                default: begin
                    ser       <= 1'b0;
                    ser_valid <= 1'b0;
                    ser_last  <= 1'b0;
                    ready_q   <= 1'b1;
                    busy_q    <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = ready_q;
    assign bus.out       = ser;
    assign bus.out_valid = ser_valid;
    assign bus.out_last  = ser_last;
    assign bus.done      = done_q;
    assign bus.busy      = busy_q;
    assign dbg_state     = state;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx (WIDTH=4, CNT_W=4); outputs are sampled on the falling edge.
// Define SEQ_PATTERN_TX_PARITY_EN to exercise the parity build instead of the plain build.
module tb_seq_pattern_tx;

    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;

    int tests_run;
    int tests_failed;

    seq_pattern_tx_if #(.WIDTH(4), .CNT_W(4)) bus ();

    seq_pattern_tx #(.WIDTH(4), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Sends one request and checks the serial stream against a hand-computed bit string
    // (MSB-first, n bits), then the done pulse and the return of in_ready.
    task automatic run_frame(input string tag, input logic [3:0] d, input logic [3:0] r,
                             input logic [63:0] bits, input int n);
        int waited;
        @(negedge clk);
        waited = 0;
        while (!bus.in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check({tag, " ready"}, {31'd0, bus.in_ready}, 32'd1);
        bus.in_data  = d;
        bus.in_reps  = r;
        bus.in_valid = 1'b1;
        for (int i = n - 1; i >= 0; i--) begin
            @(negedge clk);
            if (i == n - 1) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 4'($urandom_range(0, 15));
                bus.in_reps  = 4'($urandom_range(0, 15));
            end
            check($sformatf("%s bit%0d {valid,out,last}", tag, n - 1 - i),
                  {29'd0, bus.out_valid, bus.out, bus.out_last},
                  {29'd0, 1'b1, bits[i], (i == 0)});
        end
        @(negedge clk);
        check({tag, " done {done,ov,last,out,rdy,busy}"},
              {26'd0, bus.done, bus.out_valid, bus.out_last, bus.out, bus.in_ready, bus.busy},
              {26'd0, 6'b100001});
        @(negedge clk);
        check({tag, " idle {done,rdy,busy,ov}"},
              {28'd0, bus.done, bus.in_ready, bus.busy, bus.out_valid},
              {28'd0, 4'b0100});
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        bus.in_data  = '0;
        bus.in_reps  = '0;
        bus.in_valid = 1'b0;
        rst          = 1'b1;
        #1;
        check("reset {rdy,out,ov,last,done,busy}",
              {26'd0, bus.in_ready, bus.out, bus.out_valid, bus.out_last, bus.done, bus.busy},
              {26'd0, 6'b100000});
        check("reset state", {30'd0, dbg_state}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

`ifdef SEQ_PATTERN_TX_PARITY_EN
        run_frame("par_0111x2", 4'b0111, 4'd2, 64'b0111101111, 10);
        run_frame("par_0101x1", 4'b0101, 4'd1, 64'b01010, 5);
        run_frame("par_1000x0", 4'b1000, 4'd0, 64'b10001, 5);
`else
        run_frame("0101x1", 4'b0101, 4'd1, 64'b0101, 4);
        run_frame("0101x3", 4'b0101, 4'd3, 64'b010101010101, 12);
        run_frame("1100x0", 4'b1100, 4'd0, 64'b1100, 4);
        run_frame("1110x2", 4'b1110, 4'd2, 64'b11101110, 8);

        // in_valid held high while in_data changes mid-frame
        @(negedge clk);
        bus.in_data  = 4'b0101;
        bus.in_reps  = 4'd1;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_data = 4'b1010;
        for (int i = 3; i >= 0; i--) begin
            @(negedge clk);
            check($sformatf("hold w1 bit%0d", 3 - i),
                  {29'd0, bus.out_valid, bus.out, bus.out_last},
                  {29'd0, 1'b1, (i == 2 || i == 0), (i == 0)});
        end
        @(negedge clk);
        check("hold done {done,rdy,ov}", {29'd0, bus.done, bus.in_ready, bus.out_valid},
              {29'd0, 3'b100});
        @(negedge clk);
        check("hold re-ready {done,rdy,ov}", {29'd0, bus.done, bus.in_ready, bus.out_valid},
              {29'd0, 3'b010});
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("hold w2 bit0", {29'd0, bus.out_valid, bus.out, bus.out_last}, {29'd0, 3'b110});
        for (int i = 2; i >= 0; i--) begin
            @(negedge clk);
            check($sformatf("hold w2 bit%0d", 3 - i),
                  {29'd0, bus.out_valid, bus.out, bus.out_last},
                  {29'd0, 1'b1, (i == 1), (i == 0)});
        end
        @(negedge clk);
        check("hold w2 done", {31'd0, bus.done}, 32'd1);
        @(negedge clk);

        // reset in the middle of a 3-repetition frame
        @(negedge clk);
        bus.in_data  = 4'b0101;
        bus.in_reps  = 4'd3;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("abort bit0", {30'd0, bus.out_valid, bus.out}, {30'd0, 2'b10});
        @(negedge clk);
        check("abort bit1", {30'd0, bus.out_valid, bus.out}, {30'd0, 2'b11});
        #2;
        rst = 1'b1;
        #1;
        check("abort reset {rdy,out,ov,last,done,busy}",
              {26'd0, bus.in_ready, bus.out, bus.out_valid, bus.out_last, bus.done, bus.busy},
              {26'd0, 6'b100000});
        check("abort reset state", {30'd0, dbg_state}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("abort quiet c%0d {done,rdy,busy,ov}", i),
                  {28'd0, bus.done, bus.in_ready, bus.busy, bus.out_valid},
                  {28'd0, 4'b0100});
        end
        run_frame("post_abort 1100x0", 4'b1100, 4'd0, 64'b1100, 4);

        // full-scale repetition count, no wrap
        run_frame("1001x15", 4'b1001, 4'd15, 64'h0999_9999_9999_9999, 60);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Safety bound so the bench always ends.
    initial begin
        #200000;
        tests_run++;
        tests_failed++;
        $display("FAIL timeout: simulation bound reached");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
